// File: rtl/vga_sync_ctrl.sv
// VGA sync/timing generator: pixel-enabled h/v counters with registered sync, blanking and pulses.
// Optional 8-bar colour test pattern on rgb when VGA_SYNC_TESTPAT_EN is defined.
module vga_sync_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_SYNC_TESTPAT_EN
  ,
  output logic [11:0] rgb
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] HActEnd  = 10'(H_ACTIVE);
  localparam logic [9:0] HSyncBeg = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HSyncEnd = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] HLast    = 10'(H_TOTAL - 1);
  localparam logic [9:0] VActEnd  = 10'(V_ACTIVE);
  localparam logic [9:0] VSyncBeg = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VSyncEnd = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {PhActive, PhFront, PhSync, PhBack} phase_e;

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  phase_e     h_phase, v_phase;
  logic       hsync_d, vsync_d, video_on_d, line_start_d, frame_start_d;

  always_comb begin
    h_phase = PhBack;
    if (hcnt_q < HActEnd) begin
      h_phase = PhActive;
    end else if (hcnt_q < HSyncBeg) begin
      h_phase = PhFront;
    end else if (hcnt_q < HSyncEnd) begin
      h_phase = PhSync;
    end
  end

  always_comb begin
    v_phase = PhBack;
    if (vcnt_q < VActEnd) begin
      v_phase = PhActive;
    end else if (vcnt_q < VSyncBeg) begin
      v_phase = PhFront;
    end else if (vcnt_q < VSyncEnd) begin
      v_phase = PhSync;
    end
  end

  // vcnt only moves on the horizontal wrap, and wraps itself on that same tick.
  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == HLast) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 10'd1;
    end
  end

  always_comb begin
    hsync_d       = (h_phase == PhSync) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (v_phase == PhSync) ? SYNC_POL : ~SYNC_POL;
    video_on_d    = (h_phase == PhActive) && (v_phase == PhActive);
    line_start_d  = (hcnt_q == '0);
    frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
  end

`ifdef VGA_SYNC_TESTPAT_EN
  localparam logic [9:0] BarW = 10'(H_ACTIVE / 8);

  logic [9:0]  bar_idx;
  logic [11:0] rgb_d;

  always_comb begin
    bar_idx = hcnt_q / BarW;
    rgb_d   = 12'h000;
    if (video_on_d) begin
      case (bar_idx)
        10'd0:   rgb_d = 12'hFFF;
        10'd1:   rgb_d = 12'hFF0;
        10'd2:   rgb_d = 12'h0FF;
        10'd3:   rgb_d = 12'h0F0;
        10'd4:   rgb_d = 12'hF0F;
        10'd5:   rgb_d = 12'hF00;
        10'd6:   rgb_d = 12'h00F;
        default: rgb_d = 12'h000;
      endcase
    end
  end
`endif

  // Reset wins over a coincident pixel_tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
`ifdef VGA_SYNC_TESTPAT_EN
      rgb         <= 12'h000;
`endif
    end else if (pixel_tick) begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      video_on    <= video_on_d;
      px_x        <= hcnt_q;
      px_y        <= vcnt_q;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
`ifdef VGA_SYNC_TESTPAT_EN
      rgb         <= rgb_d;
`endif
    end
  end

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Directed bench for vga_sync_ctrl: default horizontal timing, shortened 10-row frame.
// Checks rgb too when VGA_SYNC_TESTPAT_EN is defined.
module tb_vga_sync_ctrl;

  localparam int HT = 800;
  localparam int VT = 10;  // 4 active + 2 front + 2 sync + 2 back
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pixel_tick;
  logic       hsync, vsync, video_on, line_start, frame_start;
  logic [9:0] px_x, px_y;
`ifdef VGA_SYNC_TESTPAT_EN
  logic [11:0] rgb;
`endif

  int checks = 0;
  int failures = 0;
  int n = 0;  // index of the pixel the DUT should present after the next tick
  int hs_low = 0, ls_cnt = 0, vs_low = 0, fs_cnt = 0;

  always #5 clk = ~clk;

  vga_sync_ctrl #(
    .V_ACTIVE(4),
    .V_FRONT (2),
    .V_SYNC  (2),
    .V_BACK  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_tick (pixel_tick),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .px_x       (px_x),
    .px_y       (px_y),
    .line_start (line_start),
    .frame_start(frame_start)
`ifdef VGA_SYNC_TESTPAT_EN
    ,
    .rgb        (rgb)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {px_x, px_y, hsync, vsync, video_on, line_start, frame_start}
  function automatic logic [24:0] exp_vec(input int k);
    int x, y;
    x = k % HT;
    y = (k / HT) % VT;
    return {10'(x), 10'(y), !(x >= 656 && x < 752), !(y >= 6 && y < 8),
            (x < 640 && y < 4), (x == 0), (x == 0 && y == 0)};
  endfunction

  function automatic logic [11:0] exp_rgb(input int k);
    int x, y;
    x = k % HT;
    y = (k / HT) % VT;
    if (!(x < 640 && y < 4)) return 12'h000;
    case (x / 80)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [24:0] dut_vec();
    return {px_x, px_y, hsync, vsync, video_on, line_start, frame_start};
  endfunction

  // One tick, check the presented pixel, then idle clocks with pixel_tick low.
  task automatic do_tick(input int idle);
    pixel_tick = 1'b1;
    @(posedge clk);
    #1;
    pixel_tick = 1'b0;
    chk($sformatf("pix n=%0d", n), 32'(dut_vec()), 32'(exp_vec(n)));
`ifdef VGA_SYNC_TESTPAT_EN
    chk($sformatf("rgb n=%0d", n), 32'(rgb), 32'(exp_rgb(n)));
`endif
    if (n < HT && !hsync) hs_low++;
    if (n < HT + 2 && line_start) ls_cnt++;
    if (n < FRAME && !vsync) vs_low++;
    if (n < FRAME && frame_start) fs_cnt++;
    n++;
    repeat (idle) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    pixel_tick = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vals", 32'(dut_vec()), 32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
`ifdef VGA_SYNC_TESTPAT_EN
    chk("reset_rgb", 32'(rgb), 32'h000);
`endif

    rst_n      = 1'b1;
    pixel_tick = 1'b0;
    @(posedge clk);
    #1;

    // First tick after release presents (0,0) with frame_start.
    do_tick(3);
    chk("fs_hold_between_ticks", 32'(frame_start), 32'd1);
    chk("vid_hold_between_ticks", 32'(video_on), 32'd1);

    while (n < HT + 2) do_tick(3);
    chk("hsync_low_ticks", 32'(hs_low), 32'd96);
    chk("line_start_count", 32'(ls_cnt), 32'd2);

    // Idle mid-line: nothing may move.
    repeat (50) @(posedge clk);
    #1;
    chk("idle_hold", 32'(dut_vec()), 32'(exp_vec(n - 1)));

    while (n < FRAME + 2) do_tick(0);
    chk("vsync_low_ticks", 32'(vs_low), 32'd1600);
    chk("frame_start_count", 32'(fs_cnt), 32'd1);

    // Reach (300,2) of the second frame, then reset together with a tick.
    while (n <= FRAME + 2 * HT + 300) do_tick(0);
    chk("pre_reset_x", 32'(px_x), 32'd300);
    chk("pre_reset_y", 32'(px_y), 32'd2);
    rst_n      = 1'b0;
    pixel_tick = 1'b1;
    @(posedge clk);
    #1;
    chk("midframe_reset", 32'(dut_vec()), 32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
    rst_n      = 1'b1;
    pixel_tick = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_idle", 32'(dut_vec()), 32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));

    n = 0;
    repeat (4) do_tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_ctrl.md
VGA_SYNC_CTRL -- requirements
Module: vga_sync_ctrl

Interface
REQ-001 SHALL provide parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL provide parameters H_FRONT 16, H_SYNC 96, H_BACK 48; horizontal total = sum = 800.
REQ-003 SHALL provide parameters V_ACTIVE 480, V_FRONT 10, V_SYNC 2, V_BACK 33; vertical total = sum = 525.
REQ-004 SHALL provide parameter SYNC_POL, 0, sync active level (0 = active-low).
REQ-005 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port pixel_tick  input  1  one-cycle pixel enable from the clock divider.
REQ-008 SHALL have port hsync  output  1  horizontal sync.
REQ-009 SHALL have port vsync  output  1  vertical sync.
REQ-010 SHALL have port video_on  output  1  high while the current pixel is inside the visible area.
REQ-011 SHALL have port px_x  output  10  current column, 0..H_total-1.
REQ-012 SHALL have port px_y  output  10  current row, 0..V_total-1.
REQ-013 SHALL have port line_start  output  1  one-tick pulse at column 0.
REQ-014 SHALL have port frame_start  output  1  one-tick pulse at column 0, row 0.

Function
REQ-015 SHALL hold an internal horizontal counter hcnt (10 bits) and vertical counter vcnt (10 bits).
REQ-016 SHALL change counters and outputs only on cycles where pixel_tick=1; otherwise all state holds.
REQ-017 On each tick: outputs SHALL be registered from the current hcnt/vcnt, and counters SHALL advance; latency from counter value to outputs is one tick.
REQ-018 hcnt SHALL wrap from H_total-1 to 0; vcnt SHALL increment only on that wrap and SHALL wrap from V_total-1 to 0 on the same tick.
REQ-019 Horizontal phase SHALL be decoded as ACTIVE [0,H_ACTIVE), FRONT, SYNC, BACK, in that order; vertical phase likewise.
REQ-020 hsync SHALL equal SYNC_POL in the H SYNC phase (columns 656..751 at default), else ~SYNC_POL.
REQ-021 vsync SHALL equal SYNC_POL in the V SYNC phase (rows 490..491 at default), else ~SYNC_POL.
REQ-022 video_on SHALL be 1 only when both phases are ACTIVE.
REQ-023 line_start SHALL be 1 for exactly one tick when px_x=0; frame_start when px_x=0 and px_y=0.
REQ-024 Pulses SHALL hold their value between ticks, i.e. they last from one tick until the next tick.
REQ-025 Arithmetic SHALL be unsigned 10-bit; counters SHALL never exceed total-1.

Reset
REQ-026 With rst_n=0 at a clock edge, regardless of pixel_tick: hcnt=0, vcnt=0, hsync=vsync=~SYNC_POL, video_on=0, px_x=0, px_y=0, line_start=0, frame_start=0.
REQ-027 Reset mid-frame SHALL abort the frame; the first tick after release SHALL present pixel (0,0) with frame_start=1, video_on=1.
REQ-028 Reset SHALL take precedence over a simultaneous pixel_tick.

Configuration
REQ-029 Macro VGA_SYNC_TESTPAT_EN, when defined, SHALL add output rgb (12 bits, 4:4:4), registered with the other outputs.
REQ-030 With VGA_SYNC_TESTPAT_EN: rgb SHALL show 8 vertical colour bars of width H_ACTIVE/8 (white, yellow, cyan, green, magenta, red, blue, black, channels 4'hF or 0) while video_on, else 12'h000; reset value 12'h000.
REQ-031 Without VGA_SYNC_TESTPAT_EN: no rgb port and no related logic.

Verification
REQ-032 Reset release, pixel_tick every 4th clk -> first tick px_x=0, px_y=0, frame_start=1, video_on=1, hsync=vsync=1.
REQ-033 Run one line -> hsync=0 exactly for px_x 656..751 (96 ticks), video_on=0 from px_x=640, line_start every 800 ticks.
REQ-034 Run full frame -> vsync=0 for px_y 490..491 (1600 ticks), frame_start once per 420000 ticks, px_y wraps 524->0.
REQ-035 pixel_tick held 0 for 50 clk mid-line -> all outputs unchanged.
REQ-036 rst_n=0 for one clk at px_x=300, px_y=200 with pixel_tick=1 -> reset values next cycle; next tick presents (0,0).
REQ-037 VGA_SYNC_TESTPAT_EN defined -> rgb=12'hFFF at px_x=0, 12'hF00 at px_x=400, 12'h000 at px_x=700.
